opn_write_seq: RTL and testbench

OPN_WRITE_SEQ -- requirements
Module: opn_write_seq

---
 rtl/opn_seq_pkg.sv | 40 ++++
 rtl/opn_write_seq_if.sv | 13 +
 rtl/opn_seq_timer.sv | 30 +++
 rtl/opn_write_seq.sv | 164 ++++++++++++++++
 tb/tb_opn_write_seq.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/opn_seq_pkg.sv
// Shared types and constants for the OPN register-write sequencer:
// FSM states, table entry layout and well-known OPN register addresses.
package opn_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADR_WR,
        ADR_REL,
        DAT_WR,
        DAT_REL,
        WAIT,
        FIN
    } seq_state_t;

    // Entry layout: {port[16], reg[15:8], value[7:0]}
    localparam int ENTRY_W  = 17;
    localparam int PORT_BIT = 16;
    localparam int REG_LSB  = 8;
    localparam int VAL_LSB  = 0;

    localparam logic [7:0] REG_TIMER_CTRL = 8'h27;
    localparam logic [7:0] REG_KEY_ON     = 8'h28;
    localparam logic [7:0] REG_OP_FIRST   = 8'h30;
    localparam logic [7:0] REG_OP_LAST    = 8'hB4;

    typedef logic [ENTRY_W-1:0] entry_t;

    function automatic logic [7:0] entry_reg(entry_t e);
        return e[REG_LSB +: 8];
    endfunction

    function automatic logic [7:0] entry_val(entry_t e);
        return e[VAL_LSB +: 8];
    endfunction

    function automatic logic entry_port(entry_t e);
        return e[PORT_BIT];
    endfunction

endpackage

// File: rtl/opn_write_seq_if.sv
// Chip-side bus of the OPN write sequencer: strobes, address lines,
// data out and the status byte read back from the chip.
interface opn_write_seq_if;
    logic       cs_n;
    logic       wr_n;
    logic       addr;
    logic       a1;
    logic [7:0] din;
    logic [7:0] chip_dout;

    modport master (output cs_n, wr_n, addr, a1, din, input chip_dout);
    modport slave  (input cs_n, wr_n, addr, a1, din, output chip_dout);
endinterface

// File: rtl/opn_seq_timer.sv
// Down-counter for the post-write idle gap. expired is high in the cycle
// whose closing edge brings the count to zero, so a load of N gives N cycles.
module opn_seq_timer #(
    parameter int  GAP = 476,
    localparam int W   = (GAP > 0) ? $clog2(GAP + 1) : 1
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic cen,
    input  logic load,
    input  logic count,
    output logic expired
);
    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (cen) begin
            if (load) begin
                cnt_reg <= W'(GAP);
            end else if (count && cnt_reg != '0) begin
                cnt_reg <= cnt_reg - W'(1);
            end
        end
    end

    // GAP=0 and GAP=1 both yield a single WAIT cycle
    assign expired = (cnt_reg <= W'(1));
endmodule

// File: rtl/opn_write_seq.sv
// Plays a table of {port, reg, value} entries to an OPN/OPN2 chip as
// address/data write pairs, with an idle gap (and optional busy poll) after each.
module opn_write_seq
    import opn_seq_pkg::*;
#(
    parameter int  DEPTH     = 16,
    parameter int  GAP       = 476,
    parameter int  PORTS     = 1,
    parameter int  BUSY_POLL = 0,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic            cen,
    input  logic            tbl_we,
    input  logic [AW-1:0]   tbl_addr,
    input  logic [16:0]     tbl_data,
    input  logic [AW:0]     len,
    input  logic            start,
    input  logic            abort,
    opn_write_seq_if.master bus,
    output logic            busy,
    output logic            done,
    output logic            aborted,
    output logic [AW-1:0]   idx
);
    localparam logic MULTI_PORT = (PORTS == 2);

    seq_state_t    state_reg;
    entry_t        tbl_mem [DEPTH];
    logic [AW:0]   len_reg;
    logic [AW-1:0] idx_reg;
    logic [7:0]    val_reg;
    logic          busy_reg, done_reg, aborted_reg, abort_seen_reg;
    logic          cs_n_reg, wr_n_reg, addr_reg, a1_reg;
    logic [7:0]    din_reg;

    logic [AW-1:0] next_idx;
    entry_t        next_entry;
    logic          last_entry, chip_ready, gap_done;

    // Table is frozen while a sequence plays so the entries in flight stay coherent
    always_ff @(posedge clk_in) begin
        if (tbl_we && !busy_reg) begin
            tbl_mem[tbl_addr] <= tbl_data;
        end
    end

    assign next_idx   = (state_reg == IDLE) ? '0 : idx_reg + AW'(1);
    assign next_entry = tbl_mem[next_idx];
    assign last_entry = ({1'b0, idx_reg} == len_reg - (AW+1)'(1));
    assign chip_ready = (BUSY_POLL == 0) || !bus.chip_dout[7];

    opn_seq_timer #(.GAP(GAP)) u_timer (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .cen     (cen),
        .load    (state_reg == DAT_REL),
        .count   (state_reg == WAIT),
        .expired (gap_done)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            len_reg        <= '0;
            idx_reg        <= '0;
            val_reg        <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            aborted_reg    <= 1'b0;
            abort_seen_reg <= 1'b0;
            cs_n_reg       <= 1'b1;
            wr_n_reg       <= 1'b1;
            addr_reg       <= 1'b0;
            a1_reg         <= 1'b0;
            din_reg        <= '0;
        end else begin
            // Abort is captured even on cen=0 cycles so a short pulse is never lost
            if (abort && busy_reg) begin
                abort_seen_reg <= 1'b1;
            end
            if (cen) begin
                done_reg    <= 1'b0;
                aborted_reg <= 1'b0;
                unique case (state_reg)
                    IDLE: begin
                        if (start) begin
                            len_reg        <= len;
                            idx_reg        <= '0;
                            abort_seen_reg <= 1'b0;
                            if (len == '0) begin
                                state_reg <= FIN;
                                done_reg  <= 1'b1;
                            end else begin
                                state_reg <= ADR_WR;
                                busy_reg  <= 1'b1;
                                cs_n_reg  <= 1'b0;
                                wr_n_reg  <= 1'b0;
                                addr_reg  <= 1'b0;
                                a1_reg    <= MULTI_PORT && entry_port(next_entry);
                                din_reg   <= entry_reg(next_entry);
                                val_reg   <= entry_val(next_entry);
                            end
                        end
                    end
                    ADR_WR: begin
                        state_reg <= ADR_REL;
                        wr_n_reg  <= 1'b1;
                    end
                    ADR_REL: begin
                        state_reg <= DAT_WR;
                        wr_n_reg  <= 1'b0;
                        addr_reg  <= 1'b1;
                        din_reg   <= val_reg;
                    end
                    DAT_WR: begin
                        state_reg <= DAT_REL;
                        wr_n_reg  <= 1'b1;
                    end
                    DAT_REL: begin
                        state_reg <= WAIT;
                        cs_n_reg  <= 1'b1;
                        addr_reg  <= 1'b0;
                    end
                    WAIT: begin
                        if (gap_done && chip_ready) begin
                            if (abort_seen_reg || abort || last_entry) begin
                                state_reg   <= FIN;
                                busy_reg    <= 1'b0;
                                done_reg    <= 1'b1;
                                aborted_reg <= abort_seen_reg || abort;
                            end else begin
                                state_reg <= ADR_WR;
                                idx_reg   <= next_idx;
                                cs_n_reg  <= 1'b0;
                                wr_n_reg  <= 1'b0;
                                addr_reg  <= 1'b0;
                                a1_reg    <= MULTI_PORT && entry_port(next_entry);
                                din_reg   <= entry_reg(next_entry);
                                val_reg   <= entry_val(next_entry);
                            end
                        end
                    end
                    FIN: begin
                        state_reg      <= IDLE;
                        abort_seen_reg <= 1'b0;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.cs_n = cs_n_reg;
    assign bus.wr_n = wr_n_reg;
    assign bus.addr = addr_reg;
    assign bus.a1   = a1_reg;
    assign bus.din  = din_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign aborted  = aborted_reg;
    assign idx      = idx_reg;
endmodule

// File: tb/tb_opn_write_seq.sv
// Directed bench for opn_write_seq (DEPTH=16, GAP=4, PORTS=2, BUSY_POLL=1);
// every bus write strobe is logged and printed as one line.
module tb_opn_write_seq;
    import opn_seq_pkg::*;

    logic        clk_in = 1'b0, rst_n = 1'b0, cen = 1'b1;
    logic        tbl_we = 1'b0, start = 1'b0, abort = 1'b0;
    logic [3:0]  tbl_addr = '0;
    logic [16:0] tbl_data = '0;
    logic [4:0]  len = '0;
    logic        busy, done, aborted;
    logic [3:0]  idx;

    opn_write_seq_if bus();

    opn_write_seq #(.DEPTH(16), .GAP(4), .PORTS(2), .BUSY_POLL(1)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .cen(cen), .tbl_we(tbl_we),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .len(len), .start(start),
        .abort(abort), .bus(bus), .busy(busy), .done(done),
        .aborted(aborted), .idx(idx)
    );

    typedef struct {
        logic       a1;
        logic       addr;
        logic [7:0] din;
        int         stamp;
    } strobe_t;

    strobe_t log_q[$];
    int      tot = 0, bad = 0, cyc_cnt = 0, done_cnt = 0, stray_abort = 0;
    logic    done_aborted = 1'b0;
    logic    prev_wr_n = 1'b1;

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk_in) begin
        if (!bus.wr_n && prev_wr_n) begin
            log_q.push_back('{bus.a1, bus.addr, bus.din, cyc_cnt});
            $display("strobe t=%0d a1=%0b a0=%0b din=%02h idx=%0d", cyc_cnt, bus.a1, bus.addr, bus.din, idx);
        end
        prev_wr_n = bus.wr_n;
        if (done) begin
            done_cnt++;
            done_aborted = aborted;
        end
        if (aborted && !done) stray_abort++;
    end

    task cyc();
        @(posedge clk_in);
        #1;
    endtask

    task load(input logic [3:0] a, input logic [16:0] d);
        tbl_addr = a;
        tbl_data = d;
        tbl_we   = 1'b1;
        cyc();
        tbl_we   = 1'b0;
    endtask

    task run(input logic [4:0] n);
        len   = n;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task reset_log();
        log_q.delete();
        done_cnt     = 0;
        done_aborted = 1'b0;
        stray_abort  = 0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic wait_strobe(input logic a0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.wr_n && bus.addr == a0) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task test_reset();
        rst_n = 1'b0;
        repeat (3) cyc();
        tot++;
        if ({bus.cs_n, bus.wr_n, bus.addr, bus.a1, bus.din} !== {4'b1100, 8'h00}) begin
            bad++;
            $display("FAIL reset_bus: got %b want %b", {bus.cs_n, bus.wr_n, bus.addr, bus.a1, bus.din}, {4'b1100, 8'h00});
        end
        tot++;
        if ({busy, done, aborted, idx} !== 7'b0) begin
            bad++;
            $display("FAIL reset_status: got %b want %b", {busy, done, aborted, idx}, 7'b0);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        bit ok;
        logic [7:0] exp_din [4] = '{8'h27, 8'h3B, 8'hB0, 8'h07};
        logic       exp_a0  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        reset_log();
        load(4'd0, {1'b0, REG_TIMER_CTRL, 8'h3B});
        load(4'd1, {1'b0, 8'hB0, 8'h07});
        run(5'd2);
        tot++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        load(4'd1, {1'b0, 8'hAA, 8'hAA});
        len = 5'd1; start = 1'b1; cyc(); start = 1'b0;
        wait_done(ok);
        tot++;
        if (ok !== 1'b1) begin bad++; $display("FAIL basic_timeout: got no done want done"); end
        tot++;
        if ({busy, aborted} !== 2'b00) begin bad++; $display("FAIL basic_fin: got busy/aborted=%b want 00", {busy, aborted}); end
        repeat (10) cyc();
        tot++;
        if (log_q.size() !== 4) begin bad++; $display("FAIL basic_count: got %0d want 4", log_q.size()); end
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            tot++;
            if ({log_q[i].addr, log_q[i].din} !== {exp_a0[i], exp_din[i]}) begin
                bad++;
                $display("FAIL basic_strobe[%0d]: got a0=%b din=%02h want a0=%b din=%02h", i, log_q[i].addr, log_q[i].din, exp_a0[i], exp_din[i]);
            end
        end
        if (log_q.size() >= 4) begin
            tot++;
            if (log_q[2].stamp - log_q[1].stamp !== 6) begin
                bad++;
                $display("FAIL basic_gap: got %0d cycles want 6", log_q[2].stamp - log_q[1].stamp);
            end
        end
        tot++;
        if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task test_len0();
        reset_log();
        run(5'd0);
        tot++;
        if ({done, busy} !== 2'b10) begin bad++; $display("FAIL len0_done: got done/busy=%b want 10", {done, busy}); end
        cyc();
        tot++;
        if (done !== 1'b0) begin bad++; $display("FAIL len0_pulse: got %b want 0", done); end
        repeat (3) cyc();
        tot++;
        if (log_q.size() !== 0) begin bad++; $display("FAIL len0_bus: got %0d strobes want 0", log_q.size()); end
    endtask

    task automatic test_ports();
        bit ok;
        reset_log();
        load(4'd0, {1'b1, REG_KEY_ON, 8'h10});
        run(5'd1);
        tot++;
        if ({bus.wr_n, bus.a1, bus.din} !== {2'b01, 8'h28}) begin
            bad++;
            $display("FAIL ports_adr: got %b want %b", {bus.wr_n, bus.a1, bus.din}, {2'b01, 8'h28});
        end
        cen = 1'b0;
        repeat (3) cyc();
        tot++;
        if ({bus.cs_n, bus.wr_n, bus.din} !== {2'b00, 8'h28}) begin
            bad++;
            $display("FAIL cen_freeze: got %b want %b", {bus.cs_n, bus.wr_n, bus.din}, {2'b00, 8'h28});
        end
        cen = 1'b1;
        wait_done(ok);
        tot++;
        if (ok !== 1'b1) begin bad++; $display("FAIL ports_timeout: got no done want done"); end
        cyc(); cyc();
        tot++;
        if (log_q.size() !== 2) begin
            bad++;
            $display("FAIL ports_count: got %0d want 2", log_q.size());
        end else begin
            tot++;
            if ({log_q[0].a1, log_q[1].a1, log_q[1].addr, log_q[1].din} !== {3'b111, 8'h10}) begin
                bad++;
                $display("FAIL ports_a1: got %b want %b", {log_q[0].a1, log_q[1].a1, log_q[1].addr, log_q[1].din}, {3'b111, 8'h10});
            end
        end
    endtask

    task automatic test_busy_poll();
        bit ok;
        logic low_seen;
        reset_log();
        load(4'd0, {1'b0, REG_OP_FIRST, 8'h11});
        load(4'd1, {1'b0, 8'h40, 8'h22});
        run(5'd2);
        wait_strobe(1'b1, ok);
        tot++;
        if (ok !== 1'b1) begin bad++; $display("FAIL poll_dat_timeout: got no data strobe want one"); end
        cyc();
        bus.chip_dout = 8'h80;
        low_seen = 1'b0;
        repeat (20) begin
            cyc();
            if (!bus.wr_n) low_seen = 1'b1;
        end
        tot++;
        if (low_seen !== 1'b0) begin bad++; $display("FAIL poll_hold: got strobe while busy want none"); end
        bus.chip_dout = 8'h00;
        cyc();
        tot++;
        if ({bus.wr_n, bus.addr, bus.din} !== {2'b00, 8'h40}) begin
            bad++;
            $display("FAIL poll_release: got %b want %b", {bus.wr_n, bus.addr, bus.din}, {2'b00, 8'h40});
        end
        wait_done(ok);
        tot++;
        if (ok !== 1'b1) begin bad++; $display("FAIL poll_timeout: got no done want done"); end
        cyc();
    endtask

    task automatic test_abort();
        bit ok;
        reset_log();
        load(4'd0, {1'b0, 8'h27, 8'h01});
        load(4'd1, {1'b0, 8'h28, 8'h02});
        load(4'd2, {1'b0, 8'h30, 8'h03});
        run(5'd3);
        wait_strobe(1'b1, ok);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        wait_done(ok);
        tot++;
        if (ok !== 1'b1) begin bad++; $display("FAIL abort_timeout: got no done want done"); end
        cyc(); cyc();
        tot++;
        if (log_q.size() !== 2) begin bad++; $display("FAIL abort_count: got %0d want 2", log_q.size()); end
        tot++;
        if ({done_aborted, done_cnt[1:0], stray_abort[1:0]} !== 5'b10100) begin
            bad++;
            $display("FAIL abort_flag: got aborted=%b done_cnt=%0d stray=%0d want 1,1,0", done_aborted, done_cnt, stray_abort);
        end
        abort = 1'b1; cyc(); abort = 1'b0;
        reset_log();
        run(5'd1);
        wait_done(ok);
        cyc();
        tot++;
        if ({ok, done_aborted} !== 2'b10) begin
            bad++;
            $display("FAIL idle_abort: got done/aborted=%b want 10", {ok, done_aborted});
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        reset_log();
        run(5'd2);
        wait_strobe(1'b1, ok);
        rst_n = 1'b0;
        #1;
        tot++;
        if ({bus.cs_n, bus.wr_n, busy, idx} !== 7'b1100000) begin
            bad++;
            $display("FAIL reset_mid: got %b want %b", {bus.cs_n, bus.wr_n, busy, idx}, 7'b1100000);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        reset_log();
        run(5'd2);
        wait_done(ok);
        cyc(); cyc();
        tot++;
        if (log_q.size() !== 4) begin
            bad++;
            $display("FAIL replay_count: got %0d want 4", log_q.size());
        end else begin
            tot++;
            if ({log_q[0].din, log_q[2].din} !== 16'h2728) begin
                bad++;
                $display("FAIL replay_order: got %02h,%02h want 27,28", log_q[0].din, log_q[2].din);
            end
        end
    endtask

    initial begin
        bus.chip_dout = 8'h00;
        test_reset();
        test_basic();
        test_len0();
        test_ports();
        test_busy_poll();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
